// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: holds a table of SPI configuration words and streams them,
// one transfer at a time, into the serializer's sdo valid/ready handshake.
// Reports busy, done and transfer-timeout abort to the control logic.
// Optional readback compare is compiled in when SPI_READBACK_EN is defined.
module spi_cfg_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int VALID_CYCLES = 2,
  parameter int GAP_CYCLES   = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     cfg_wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] cfg_wr_addr_i,
  input  logic [DATA_WIDTH-1:0]    cfg_wr_data_i,
  input  logic                     start_i,
  input  logic [$clog2(DEPTH):0]   num_words_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [$clog2(DEPTH):0]   word_idx_o,
  output logic [DATA_WIDTH-1:0]    sdo_data_o,
  output logic                     sdo_valid_o,
  input  logic                     sdo_ready_i,
  output logic                     sdi_ready_o,
  input  logic [DATA_WIDTH-1:0]    sdi_data_i,
  input  logic                     sdi_valid_i,
  output logic                     mismatch_o
);

  localparam int AW        = $clog2(DEPTH);
  localparam int CNT_MAX_A = (VALID_CYCLES > GAP_CYCLES) ? VALID_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX   = (TIMEOUT > CNT_MAX_A) ? TIMEOUT : CNT_MAX_A;
  localparam int CW        = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    IDLE,
    PRESENT,
    RELEASE,
    SHIFT,
    GAP,
`ifdef SPI_READBACK_EN
    RB_REQ,
    RB_WAIT,
`endif
    DONE,
    ERROR
  } state_e;

  state_e                state_q, state_d;
  state_e                word_end_state;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW:0]           word_idx_q, word_idx_d;
  logic [AW:0]           num_words_q, num_words_d;
  logic [AW:0]           idx_inc;
  logic [AW:0]           nw_clamped;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] cur_word;
  logic                  valid_last;
  logic                  gap_last;
  logic                  timed_out;
  logic                  show_data;

`ifdef SPI_READBACK_EN
  logic mismatch_q, mismatch_d;
`endif

  // The table is deliberately not reset; writes only land while no sequence runs
  always_ff @(posedge clk_i) begin
    if (cfg_wr_en_i && !busy_o) begin
      mem[cfg_wr_addr_i] <= cfg_wr_data_i;
    end
  end

  assign cur_word   = mem[word_idx_q[AW-1:0]];
  assign idx_inc    = word_idx_q + 1'b1;
  assign nw_clamped = (num_words_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_words_i;
  assign valid_last = (cnt_q == CW'(VALID_CYCLES - 1));
  assign gap_last   = (cnt_q == CW'(GAP_CYCLES - 1));
  assign timed_out  = (cnt_q >= CW'(TIMEOUT - 1));

  // Where a finished word goes next: straight to PRESENT/DONE when there is no gap
  always_comb begin
    word_end_state = GAP;
    if (GAP_CYCLES == 0) begin
      word_end_state = (idx_inc == num_words_q) ? DONE : PRESENT;
    end
  end

  // State, counter, index and flag registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_idx_q  <= '0;
      num_words_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_idx_q  <= word_idx_d;
      num_words_q <= num_words_d;
    end
  end

`ifdef SPI_READBACK_EN
  // Sticky readback mismatch flag
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end
`endif

  // Next-state logic; the shared counter restarts on every state change
  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    num_words_d = num_words_q;
`ifdef SPI_READBACK_EN
    mismatch_d  = mismatch_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        state_d = IDLE;
        if (start_i) begin
          word_idx_d  = '0;
          num_words_d = nw_clamped;
`ifdef SPI_READBACK_EN
          mismatch_d  = 1'b0;
`endif
          state_d     = (nw_clamped == '0) ? DONE : PRESENT;
        end
      end
      PRESENT: begin
        if (valid_last) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (sdo_ready_i) begin
          state_d = SHIFT;
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
      SHIFT: begin
        if (!sdo_ready_i) begin
`ifdef SPI_READBACK_EN
          state_d = RB_REQ;
`else
          word_idx_d = idx_inc;
          state_d    = word_end_state;
`endif
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
`ifdef SPI_READBACK_EN
      RB_REQ: begin
        state_d = RB_WAIT;
      end
      RB_WAIT: begin
        if (sdi_valid_i) begin
          if (sdi_data_i != cur_word) begin
            mismatch_d = 1'b1;
          end
          word_idx_d = idx_inc;
          state_d    = word_end_state;
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
`endif
      GAP: begin
        if (gap_last) begin
          state_d = (word_idx_q == num_words_q) ? DONE : PRESENT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(CNT_MAX)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef SPI_READBACK_EN
  assign show_data   = (state_q inside {PRESENT, RELEASE, SHIFT, RB_REQ, RB_WAIT});
  assign sdi_ready_o = (state_q == RB_REQ);
  assign mismatch_o  = mismatch_q;
`else
  logic unused_sdi;
  assign unused_sdi  = ^{sdi_valid_i, sdi_data_i};
  assign show_data   = (state_q inside {PRESENT, RELEASE, SHIFT});
  assign sdi_ready_o = 1'b0;
  assign mismatch_o  = 1'b0;
`endif

  assign busy_o      = !(state_q inside {IDLE, DONE, ERROR});
  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == ERROR);
  assign sdo_valid_o = (state_q == PRESENT);
  assign sdo_data_o  = show_data ? cur_word : '0;
  assign word_idx_o  = word_idx_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb_spi_cfg_sequencer: directed self-checking bench for spi_cfg_sequencer with
// a small serializer model and transfer monitor. Define SPI_READBACK_EN to
// exercise the readback compare path.
`timescale 1ns/1ps
module tb_spi_cfg_sequencer;

  localparam int DW = 32;
`ifdef SPI_READBACK_EN
  localparam int RB_EXTRA = 2;
`else
  localparam int RB_EXTRA = 0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          cfg_wr_en_i;
  logic [3:0]    cfg_wr_addr_i;
  logic [DW-1:0] cfg_wr_data_i;
  logic          start_i;
  logic [4:0]    num_words_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [4:0]    word_idx_o;
  logic [DW-1:0] sdo_data_o;
  logic          sdo_valid_o;
  logic          sdo_ready_i;
  logic          sdi_ready_o;
  logic [DW-1:0] sdi_data_i;
  logic          sdi_valid_i;
  logic          mismatch_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_table [16];

  int            ser_mode;
  bit            seen_valid;
  int            ser_cnt;
  bit            prev_valid;
  bit            idle_on;
  int            idle_cnt;
  int            n_xfer;
  int            done_cnt;
  int            err_cnt;
  int            rb_hold;
  int            rb_total = 0;
  logic [DW-1:0] xfer_data [32];
  int            xfer_len  [32];
  int            xfer_gap  [32];
  bit            xfer_mm   [32];

  spi_cfg_sequencer dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .cfg_wr_en_i   (cfg_wr_en_i),
    .cfg_wr_addr_i (cfg_wr_addr_i),
    .cfg_wr_data_i (cfg_wr_data_i),
    .start_i       (start_i),
    .num_words_i   (num_words_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .word_idx_o    (word_idx_o),
    .sdo_data_o    (sdo_data_o),
    .sdo_valid_o   (sdo_valid_o),
    .sdo_ready_i   (sdo_ready_i),
    .sdi_ready_o   (sdi_ready_o),
    .sdi_data_i    (sdi_data_i),
    .sdi_valid_i   (sdi_valid_i),
    .mismatch_o    (mismatch_o)
  );

  // 100 MHz clock
  always #5 clk_i = ~clk_i;

  // Monitor plus serializer/readback model, sampling 1ns after each rising edge.
  // Ready rises 2 cycles after valid falls and stays high for 32 cycles.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (done_o === 1'b1) done_cnt++;
      if (err_o === 1'b1) err_cnt++;
      if (sdi_ready_o === 1'b1) rb_total++;
      if (sdo_valid_o === 1'b1 && !prev_valid) begin
        if (n_xfer < 32) begin
          xfer_data[n_xfer] = sdo_data_o;
          xfer_len[n_xfer]  = 0;
          xfer_gap[n_xfer]  = idle_on ? idle_cnt : -1;
          xfer_mm[n_xfer]   = mismatch_o;
        end
        n_xfer++;
        idle_on = 1'b0;
      end
      if (sdo_valid_o === 1'b1 && n_xfer > 0 && n_xfer <= 32) xfer_len[n_xfer-1]++;
      if (sdo_valid_o !== 1'b1 && idle_on) idle_cnt++;
      prev_valid = (sdo_valid_o === 1'b1);
      if (ser_mode == 1) begin
        if (sdo_valid_o === 1'b1) begin
          seen_valid = 1'b1;
          ser_cnt    = 0;
        end else if (seen_valid) begin
          ser_cnt++;
          if (ser_cnt == 2) begin
            sdo_ready_i = 1'b1;
          end else if (ser_cnt == 34) begin
            sdo_ready_i = 1'b0;
            seen_valid  = 1'b0;
            idle_on     = 1'b1;
            idle_cnt    = 0;
          end
        end
      end
      if (rb_hold > 0) begin
        rb_hold--;
        if (rb_hold == 0) sdi_valid_i = 1'b0;
      end else if (sdi_ready_o === 1'b1) begin
        sdi_valid_i = 1'b1;
        sdi_data_i  = (word_idx_o == 5'd1) ? 32'hDEAD_BEEF : exp_table[word_idx_o[3:0]];
        rb_hold     = 2;
      end
    end
  end

  // Hard stop in case something hangs outside a bounded wait
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got hang expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clearModel();
    n_xfer      = 0;
    done_cnt    = 0;
    err_cnt     = 0;
    idle_on     = 1'b0;
    idle_cnt    = 0;
    seen_valid  = 1'b0;
    ser_cnt     = 0;
    prev_valid  = 1'b0;
    rb_hold     = 0;
    sdi_valid_i = 1'b0;
    sdo_ready_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      xfer_data[i] = '0;
      xfer_len[i]  = 0;
      xfer_gap[i]  = 0;
      xfer_mm[i]   = 1'b0;
    end
  endtask

  task automatic writeWord(input logic [3:0] addr, input logic [DW-1:0] data);
    cfg_wr_en_i   = 1'b1;
    cfg_wr_addr_i = addr;
    cfg_wr_data_i = data;
    tick();
    cfg_wr_en_i   = 1'b0;
  endtask

  task automatic startSeq(input logic [4:0] n);
    start_i     = 1'b1;
    num_words_i = n;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cycles);
    cycles = 0;
    while (done_o !== 1'b1 && err_o !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({busy_o, done_o, err_o, sdo_valid_o, sdi_ready_o, mismatch_o} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {busy_o, done_o, err_o, sdo_valid_o, sdi_ready_o, mismatch_o});
    end
    checks++;
    if (word_idx_o !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_word_idx: got %0d expected 0", word_idx_o);
    end
    checks++;
    if (sdo_data_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_sdo_data: got %h expected 0", sdo_data_o);
    end
  endtask

  task automatic test_basic();
    int cyc;
    clearModel();
    ser_mode = 1;
    startSeq(5'd3);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_busy: got %b expected 1", busy_o);
    end
    waitDone(600, cyc);
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_done: got %b expected 1 after %0d cycles", done_o, cyc);
    end
    checks++;
    if (word_idx_o !== 5'd3) begin
      errors++;
      $display("[TB] FAIL basic_word_idx: got %0d expected 3", word_idx_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_busy_at_done: got %b expected 0", busy_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_done_pulse: got %b expected 0", done_o);
    end
    checks++;
    if (n_xfer !== 3) begin
      errors++;
      $display("[TB] FAIL basic_xfer_count: got %0d expected 3", n_xfer);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (xfer_data[i] !== exp_table[i]) begin
        errors++;
        $display("[TB] FAIL basic_data[%0d]: got %h expected %h", i, xfer_data[i], exp_table[i]);
      end
      checks++;
      if (xfer_len[i] !== 2) begin
        errors++;
        $display("[TB] FAIL basic_valid_len[%0d]: got %0d expected 2", i, xfer_len[i]);
      end
      if (i > 0) begin
        checks++;
        if (xfer_gap[i] !== 4 + RB_EXTRA) begin
          errors++;
          $display("[TB] FAIL basic_gap[%0d]: got %0d expected %0d", i, xfer_gap[i], 4 + RB_EXTRA);
        end
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL basic_done_count: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_zero_words();
    clearModel();
    ser_mode = 1;
    startSeq(5'd0);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_done_next: got done=%b busy=%b expected done=1 busy=0", done_o, busy_o);
    end
    repeat (6) tick();
    checks++;
    if (n_xfer !== 0 || done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL zero_no_xfer: got xfers=%0d dones=%0d expected 0 and 1", n_xfer, done_cnt);
    end
  endtask

  task automatic test_clamp();
    int cyc;
    clearModel();
    ser_mode = 1;
    startSeq(5'd20);
    waitDone(1000, cyc);
    checks++;
    if (done_o !== 1'b1 || word_idx_o !== 5'd16) begin
      errors++;
      $display("[TB] FAIL clamp_done: got done=%b idx=%0d expected done=1 idx=16", done_o, word_idx_o);
    end
    tick();
    checks++;
    if (n_xfer !== 16) begin
      errors++;
      $display("[TB] FAIL clamp_xfer_count: got %0d expected 16", n_xfer);
    end
    checks++;
    if (xfer_data[15] !== exp_table[15]) begin
      errors++;
      $display("[TB] FAIL clamp_last_data: got %h expected %h", xfer_data[15], exp_table[15]);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL clamp_done_count: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_timeout();
    int k;
    int n;
    int cyc;
    clearModel();
    ser_mode = 0;
    startSeq(5'd1);
    k = 0;
    while (sdo_valid_o === 1'b1 && k < 10) begin
      tick();
      k++;
    end
    n = 0;
    while (err_o !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 1023) begin
      errors++;
      $display("[TB] FAIL timeout_cycles: got %0d expected 1023", n);
    end
    checks++;
    if (word_idx_o !== 5'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_state: got idx=%0d busy=%b expected idx=0 busy=0", word_idx_o, busy_o);
    end
    tick();
    checks++;
    if (err_o !== 1'b0 || err_cnt !== 1 || done_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL timeout_err_pulse: got err=%b errs=%0d dones=%0d expected 0 1 0",
               err_o, err_cnt, done_cnt);
    end
    clearModel();
    ser_mode = 1;
    startSeq(5'd1);
    waitDone(200, cyc);
    checks++;
    if (done_o !== 1'b1 || xfer_data[0] !== exp_table[0]) begin
      errors++;
      $display("[TB] FAIL timeout_recover: got done=%b data=%h expected done=1 data=%h",
               done_o, xfer_data[0], exp_table[0]);
    end
    tick();
  endtask

  task automatic test_ignore_while_busy();
    int cyc;
    clearModel();
    ser_mode = 1;
    startSeq(5'd2);
    repeat (5) tick();
    start_i       = 1'b1;
    num_words_i   = 5'd0;
    cfg_wr_en_i   = 1'b1;
    cfg_wr_addr_i = 4'd1;
    cfg_wr_data_i = 32'hFFFF_FFFF;
    tick();
    start_i       = 1'b0;
    cfg_wr_en_i   = 1'b0;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_start_ignored: got done=%b busy=%b expected 0 1", done_o, busy_o);
    end
    waitDone(400, cyc);
    checks++;
    if (done_o !== 1'b1 || word_idx_o !== 5'd2) begin
      errors++;
      $display("[TB] FAIL busy_seq_done: got done=%b idx=%0d expected 1 2", done_o, word_idx_o);
    end
    tick();
    checks++;
    if (n_xfer !== 2 || done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL busy_counts: got xfers=%0d dones=%0d expected 2 1", n_xfer, done_cnt);
    end
    checks++;
    if (xfer_data[1] !== exp_table[1]) begin
      errors++;
      $display("[TB] FAIL busy_write_dropped: got %h expected %h", xfer_data[1], exp_table[1]);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clearModel();
    ser_mode = 1;
    startSeq(5'd1);
    k = 0;
    while (sdo_ready_i !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    repeat (2) tick();
    checks++;
    if (sdo_data_o !== exp_table[0] || busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL shift_hold: got data=%h busy=%b expected %h 1", sdo_data_o, busy_o, exp_table[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, err_o, sdo_valid_o} !== 4'b0 || sdo_data_o !== 32'h0 || word_idx_o !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_in_shift: got flags=%b data=%h idx=%0d expected all 0",
               {busy_o, done_o, err_o, sdo_valid_o}, sdo_data_o, word_idx_o);
    end
    ser_mode = 0;
    clearModel();
    @(negedge clk_i);
    rst_n = 1'b1;
    tick();
    startSeq(5'd1);
    checks++;
    if (sdo_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL present_valid: got %b expected 1", sdo_valid_o);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (sdo_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_present: got valid=%b busy=%b expected 0 0", sdo_valid_o, busy_o);
    end
    @(negedge clk_i);
    rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (done_cnt !== 0 || err_cnt !== 0 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_abort: got dones=%0d errs=%0d busy=%b expected 0 0 0",
               done_cnt, err_cnt, busy_o);
    end
  endtask

`ifdef SPI_READBACK_EN
  task automatic test_readback();
    int cyc;
    clearModel();
    ser_mode = 1;
    startSeq(5'd3);
    waitDone(800, cyc);
    checks++;
    if (done_o !== 1'b1 || mismatch_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rb_done_mismatch: got done=%b mm=%b expected 1 1", done_o, mismatch_o);
    end
    checks++;
    if (n_xfer !== 3 || xfer_mm[0] !== 1'b0 || xfer_mm[1] !== 1'b0 || xfer_mm[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rb_mismatch_timing: got xfers=%0d mm=%b%b%b expected 3 001",
               n_xfer, xfer_mm[0], xfer_mm[1], xfer_mm[2]);
    end
    tick();
    checks++;
    if (mismatch_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rb_sticky: got %b expected 1", mismatch_o);
    end
    startSeq(5'd0);
    checks++;
    if (mismatch_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rb_clear_on_start: got %b expected 0", mismatch_o);
    end
    tick();
  endtask
`else
  task automatic test_no_readback();
    checks++;
    if (rb_total !== 0 || mismatch_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_readback: got sdi_ready cycles=%0d mm=%b expected 0 0", rb_total, mismatch_o);
    end
  endtask
`endif

  // Main sequence: reset, load the table, then run each scenario in turn
  initial begin
    rst_n         = 1'b0;
    cfg_wr_en_i   = 1'b0;
    cfg_wr_addr_i = '0;
    cfg_wr_data_i = '0;
    start_i       = 1'b0;
    num_words_i   = '0;
    sdo_ready_i   = 1'b0;
    sdi_data_i    = '0;
    sdi_valid_i   = 1'b0;
    ser_mode      = 0;
    clearModel();
    for (int i = 0; i < 16; i++) exp_table[i] = 32'h1000_0000 + 32'(i);
    exp_table[0] = 32'hA5A5_0001;
    exp_table[1] = 32'h0000_FFFF;
    exp_table[2] = 32'h8000_0000;

    test_reset();
    @(negedge clk_i);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) writeWord(4'(i), exp_table[i]);

    test_basic();
    test_zero_words();
    test_clamp();
    test_timeout();
    test_ignore_while_busy();
    test_reset_mid();
`ifdef SPI_READBACK_EN
    test_readback();
`else
    test_no_readback();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
